// File: rtl/axis_i2s_rx_pkg.sv
// Shared I2S definitions: receiver/transmitter FSM state encoding and channel constants.
package axis_i2s_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } i2s_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  function automatic logic is_right(input logic ch);
    return (ch == CH_RIGHT);
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Oversampling synchronizer for the three I2S pins plus a registered sclk rising-edge strobe.
// lrck/data are re-registered alongside the strobe so all three come from the same stage.
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sclk_i,
  input  logic lrck_i,
  input  logic data_i,
  output logic sclk_rise_o,
  output logic lrck_o,
  output logic data_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_rise_q;
  logic                   lrck_q;
  logic                   data_q;

  // Synchronizer chains and edge-detect state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      lrck_sync_q <= {SYNC_STAGES{1'b0}};
      data_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      lrck_q      <= 1'b0;
      data_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      lrck_q      <= lrck_sync_q[SYNC_STAGES-1];
      data_q      <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = sclk_rise_q;
  assign lrck_o      = lrck_q;
  assign data_o      = data_q;

endmodule

// File: rtl/axis_i2s_rx.sv
// I2S receiver: deserializes left/right channel words and presents each one as an AXI4-Stream beat
// through a single-entry output register with sticky overflow and framing-error flags.
import axis_i2s_rx_pkg::*;

module axis_i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic                  sclk_rise_s;
  logic                  lrck_s;
  logic                  data_s;
  logic                  lrck_prev_q;
  logic                  lrck_seen_q;
  logic                  lrck_edge_s;
  i2s_state_e            state_q;
  logic                  channel_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH:0]   shift_s;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic                  word_done_s;
  logic                  frame_err_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  overflow_q;

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk_i      (aclk),
    .reset_i    (reset),
    .sclk_i     (i2s_sclk),
    .lrck_i     (i2s_lrck),
    .data_i     (i2s_data),
    .sclk_rise_o(sclk_rise_s),
    .lrck_o     (lrck_s),
    .data_o     (data_s)
  );

  // The first strobe after reset only primes lrck history, so a mid-slot release is not an edge.
  assign lrck_edge_s = sclk_rise_s & lrck_seen_q & (lrck_s != lrck_prev_q);

  // Shifting every accepted bit lets the MSB capture in SKIP reuse the normal shift path.
  assign shift_s = {shreg_q, data_s};
  assign shreg_d = shift_s[DATA_WIDTH-1:0];

  assign word_done_s = enable & sclk_rise_s & ~lrck_edge_s &
                       (((state_q == ST_SKIP)  && (LAST_CNT == {CNT_W{1'b0}})) ||
                        ((state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT)));

  // lrck history sampled at each sclk rise.
  always_ff @(posedge aclk) begin
    if (reset) begin
      lrck_prev_q <= 1'b0;
      lrck_seen_q <= 1'b0;
    end else if (sclk_rise_s) begin
      lrck_prev_q <= lrck_s;
      lrck_seen_q <= 1'b1;
    end
  end

  // Word-alignment and bit-capture state machine.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      channel_q   <= CH_LEFT;
      bit_cnt_q   <= {CNT_W{1'b0}};
      shreg_q     <= {DATA_WIDTH{1'b0}};
      frame_err_q <= 1'b0;
    end else if (!enable) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= {CNT_W{1'b0}};
    end else if (sclk_rise_s) begin
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (lrck_edge_s) begin
            channel_q <= lrck_s;
            state_q   <= ST_SKIP;
          end
        end
        ST_SKIP, ST_SHIFT: begin
          if (lrck_edge_s) begin
            frame_err_q <= 1'b1;
            channel_q   <= lrck_s;
            bit_cnt_q   <= {CNT_W{1'b0}};
            state_q     <= ST_SKIP;
          end else begin
            shreg_q <= shreg_d;
            if (word_done_s) begin
              bit_cnt_q <= {CNT_W{1'b0}};
              state_q   <= ST_WAIT;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              state_q   <= ST_SHIFT;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output register: a new word loads when empty or draining, otherwise it is dropped.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tdata_q    <= {DATA_WIDTH{1'b0}};
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (word_done_s && (!tvalid_q || m_axis_tready)) begin
      tdata_q  <= shreg_d;
      tlast_q  <= channel_q;
      tvalid_q <= 1'b1;
    end else if (word_done_s) begin
      overflow_q <= 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_axis_i2s_rx.sv
// Bench for axis_i2s_rx: drives I2S slots at sclk = aclk/8 and scoreboards the AXI-Stream beats.
module tb_axis_i2s_rx;

  localparam int W = 24;
  localparam logic [W-1:0] WA = 24'hABCDEF;
  localparam logic [W-1:0] WB = 24'h123456;

  logic         aclk   = 1'b0;
  logic         reset  = 1'b1;
  logic         enable = 1'b1;
  logic         sclk   = 1'b0;
  logic         lrck   = 1'b0;
  logic         sdata  = 1'b0;
  logic         tready = 1'b1;
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         ovf;
  logic         ferr;

  int           tests = 0;
  int           fails = 0;
  logic [W:0]   exp_q[$];
  logic         hold_chk = 1'b0;
  logic [W:0]   hold_val = '0;

  typedef struct {
    logic         lr;
    logic [W-1:0] word;
    int           nsclk;
    logic         push;
    logic         exp_ferr;
  } vec_t;
  vec_t vecs[9];

  always #5 aclk = ~aclk;

  axis_i2s_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .aclk         (aclk),
    .reset        (reset),
    .enable       (enable),
    .i2s_sclk     (sclk),
    .i2s_lrck     (lrck),
    .i2s_data     (sdata),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .overflow     (ovf),
    .frame_err    (ferr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One aclk cycle; beats accepted at the coming edge are scoreboarded first.
  task automatic tick();
    logic [W:0] e;
    if (hold_chk) begin
      check("hold_valid", {31'd0, tvalid}, 32'd1);
      check("hold_stable", {7'd0, tlast, tdata}, {7'd0, hold_val});
    end
    hold_chk = tvalid && !tready;
    hold_val = {tlast, tdata};
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", tdata, tlast);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", {8'd0, tdata}, {8'd0, e[W-1:0]});
        check("beat_last", {31'd0, tlast}, {31'd0, e[W]});
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    sclk  = 1'b0;
    lrck  = lr;
    sdata = d;
    repeat (4) tick();
    sclk = 1'b1;
    repeat (4) tick();
  endtask

  // Sclk index 0 of a slot carries the delay bit; 1..W carry the word MSB first.
  function automatic logic slot_bit(input logic [W-1:0] word, input int k);
    if (k >= 1 && k <= W) return word[W-k];
    return 1'b0;
  endfunction

  task automatic send_range(input logic lr, input logic [W-1:0] word, input int k0, input int k1);
    for (int k = k0; k < k1; k++) send_bit(lr, slot_bit(word, k));
  endtask

  task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nsclk, input logic push);
    if (push) exp_q.push_back({lr, word});
    send_range(lr, word, 0, nsclk);
  endtask

  task automatic drain();
    repeat (40) tick();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, {31'd0, tvalid}, 32'd0);
    check({tag, "_tdata"}, {8'd0, tdata}, 32'd0);
    check({tag, "_tlast"}, {31'd0, tlast}, 32'd0);
    check({tag, "_overflow"}, {31'd0, ovf}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, ferr}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, WA,          32, 1'b1, 1'b0};
    vecs[1] = '{1'b1, WB,          32, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 24'h800001,  32, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 24'h7FFFFE,  32, 1'b1, 1'b0};
    vecs[4] = '{1'b0, WA,          32, 1'b1, 1'b0};
    vecs[5] = '{1'b1, WB,          32, 1'b1, 1'b0};
    vecs[6] = '{1'b0, WA,          16, 1'b0, 1'b0};
    vecs[7] = '{1'b1, WB,          32, 1'b1, 1'b1};
    vecs[8] = '{1'b0, WA,          32, 1'b1, 1'b1};

    repeat (5) tick();
    check_idle_outputs("reset");

    // Reset released mid-left-slot: first beat must be the complete right word.
    send_range(1'b0, WA, 0, 10);
    reset = 1'b0;
    send_range(1'b0, WA, 10, 32);
    send_slot(1'b1, WB, 32, 1'b1);

    for (int i = 0; i < 9; i++) begin
      send_slot(vecs[i].lr, vecs[i].word, vecs[i].nsclk, vecs[i].push);
      check("row_frame_err", {31'd0, ferr}, {31'd0, vecs[i].exp_ferr});
      check("row_overflow", {31'd0, ovf}, 32'd0);
    end
    drain();

    // Backpressure: first word held, second dropped.
    tready = 1'b0;
    send_slot(1'b1, WB, 32, 1'b1);
    send_slot(1'b0, WA, 32, 1'b0);
    check("bp_overflow", {31'd0, ovf}, 32'd1);
    check("bp_tvalid", {31'd0, tvalid}, 32'd1);
    check("bp_tdata", {8'd0, tdata}, {8'd0, WB});
    check("bp_tlast", {31'd0, tlast}, 32'd1);
    tready = 1'b1;
    send_slot(1'b1, WB, 32, 1'b1);
    send_slot(1'b0, WA, 32, 1'b1);
    drain();

    // Reset during bit 10 of a left word.
    send_slot(1'b1, WB, 32, 1'b1);
    drain();
    send_range(1'b0, WA, 0, 11);
    reset = 1'b1;
    tick();
    check_idle_outputs("midreset");
    reset = 1'b0;
    send_range(1'b0, WA, 11, 32);
    send_slot(1'b1, WB, 32, 1'b1);
    send_slot(1'b0, WA, 32, 1'b1);
    drain();

    // enable=0 mid-word with a held beat.
    tready = 1'b0;
    send_slot(1'b1, WB, 32, 1'b1);
    send_range(1'b0, WA, 0, 11);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    send_range(1'b0, WA, 11, 32);
    check("en_tvalid", {31'd0, tvalid}, 32'd1);
    check("en_tdata", {8'd0, tdata}, {8'd0, WB});
    check("en_tlast", {31'd0, tlast}, 32'd1);
    check("en_overflow", {31'd0, ovf}, 32'd0);
    tready = 1'b1;
    send_slot(1'b1, WB, 32, 1'b1);
    send_slot(1'b0, WA, 32, 1'b1);
    drain();

    // Ramp at the minimum slot width (DATA_WIDTH+1 sclk).
    for (int i = 1; i <= 256; i++) begin
      send_slot(((i % 2) == 1) ? 1'b1 : 1'b0, W'(i), W + 1, 1'b1);
    end
    drain();
    check("ramp_frame_err", {31'd0, ferr}, 32'd0);
    check("ramp_overflow", {31'd0, ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_i2s_rx.md
Name: axis_i2s_rx

Overview:
I2S receiver (deserializer): samples an external I2S serial stream and emits each received channel word as an AXI4-Stream beat. Sits directly downstream of the I2S transmitter/codec ADC. Used in the tx->rx loopback build, where its stream output feeds the audio sink or back into the tx path. Fully synchronous to aclk; I2S pins are treated as asynchronous and oversampled.

Parameters:
DATA_WIDTH, 24, bits per channel word captured and output, MSB first (1..32).
SYNC_STAGES, 2, flip-flop synchronizer depth on i2s_sclk, i2s_lrck and i2s_data (>=2).

Ports:
aclk  in  1  system clock; sclk must be <= aclk/4.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = receive; 0 = receiver FSM forced to IDLE.
i2s_sclk  in  1  I2S bit clock (asynchronous).
i2s_lrck  in  1  I2S word select: 0 = left, 1 = right.
i2s_data  in  1  I2S serial data, changes on sclk falling edge.
m_axis_tdata  out  DATA_WIDTH  received sample, two's complement, MSB-aligned as sent.
m_axis_tvalid  out  1  sample valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  1 = right-channel word (end of stereo frame).
overflow  out  1  sticky: word dropped due to backpressure.
frame_err  out  1  sticky: lrck changed before DATA_WIDTH bits were captured.

Behaviour:
- Reset: all outputs 0, FSM IDLE, synchronizers and edge-detect registers cleared. Sticky flags cleared only by reset.
- Input path: each pin passes SYNC_STAGES flops. sclk rising edge detected as sync=1 and previous sync=0; every action below happens only on an aclk cycle carrying an sclk rising-edge strobe (sclk_rise). lrck and data are sampled from the same synchronizer stage as sclk.
- lrck_edge: on sclk_rise, sampled lrck differs from lrck sampled at the previous sclk_rise.
- FSM states: IDLE, SKIP, SHIFT, WAIT.
  IDLE: wait for lrck_edge (ensures word alignment after reset or enable), then latch channel = new lrck and go to SKIP. Outside IDLE, enable=0 forces IDLE on the next cycle with the partial word discarded.
  SKIP: the bit sampled on the lrck_edge strobe is ignored (I2S one-bit delay). On the next sclk_rise, capture the MSB, set bit_cnt=1 and go to SHIFT.
  SHIFT: each sclk_rise shifts data into the LSB of shreg and increments bit_cnt. When bit_cnt reaches DATA_WIDTH, issue a word-done pulse and go to WAIT.
  WAIT: ignore remaining slot bits. On lrck_edge, latch channel and go to SKIP.
- lrck_edge in SHIFT (short word): discard the partial word, set frame_err, latch the new channel and go to SKIP.
- Output register: one-entry skid.
  On word done, if m_axis_tvalid=0 or m_axis_tready=1 that cycle, load tdata=shreg and tlast=channel, and set tvalid=1 on the next cycle.
  Otherwise, keep the held beat unchanged, drop the new word and set overflow.
  tvalid falls the cycle after tvalid&tready unless a new word loads in the same cycle; simultaneous accept and load gives back-to-back valid.
- AXIS rules:
  tdata and tlast are stable while tvalid=1 and tready=0.
  tvalid does not depend on tready.
  enable=0 does not drop an already held beat.
- Latency: tvalid rises 1 aclk after the aclk cycle in which the LSB's sclk_rise strobe occurs. That strobe trails the pin edge by SYNC_STAGES+1 aclk.
- Slot width is free: any sclk count per half-frame >= DATA_WIDTH+1 works. Shorter slots produce frame_err every word.

Decomposition:
- Shared i2s package: FSM state encoding (IDLE, SKIP, SHIFT, WAIT) and channel constants (CH_LEFT=0, CH_RIGHT=1). These constants are reused by the tx block.
- One natural sub-module: i2s_pin_sync. It provides the SYNC_STAGES synchronizer for the three pins and the sclk rising-edge strobe, and the tx side can reuse it for external-clock mode.

Test Plan:
- Basic stereo: bench drives sclk = aclk/8, 32-bit slots, left 0xABCDEF and right 0x123456, tready=1. Expected beats: 0xABCDEF with tlast=0, then 0x123456 with tlast=1, repeating every frame. No flags set.
- Alignment: release reset mid-left-slot. Expected: no beat until after the first lrck edge. The first beat is a complete right word 0x123456 with tlast=1.
- Backpressure: hold tready=0 for two words. Expected: the first word is held with stable tdata, the second is dropped and overflow=1. After tready=1 the held beat is accepted, and the next beat is the following correct word.
- Short slot: one left slot of only 16 sclk with DATA_WIDTH=24. Expected: frame_err=1, no beat for that word, and the following right word 0x123456 is received correctly.
- Reset and enable mid-word: assert reset during bit 10 of a left word. Expected: all outputs 0 on the next cycle and resync on the next lrck edge. Repeat using enable=0; a held beat survives and no partial word is emitted.
- Loopback: tx to rx at DATA_WIDTH=24 with a ramp of 0x000001..0x000100. Expected: all 256 words received in order with alternating tlast.
